mem_addr_responder: RTL and testbench



---
 rtl/mem_addr_responder_if.sv | 37 +++
 rtl/mem_addr_responder.sv | 153 +++++++++++++++
 tb/tb_mem_addr_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_addr_responder_if.sv
// Request/response bus between the CPU address-bus master and the memory responder.
// Defining MEM_RESP_ADDR_ECHO_EN adds rsp_addr, which echoes the request address in the response.
interface mem_addr_responder_if #(
   parameter int ADDR_SIZE = 19,
   parameter int DATA_SIZE = 19
);
   logic                 req_valid;
   logic                 req_ready;
   logic [ADDR_SIZE-1:0] req_addr;
   logic                 req_we;
   logic [DATA_SIZE-1:0] req_wdata;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [DATA_SIZE-1:0] rsp_rdata;
   logic                 rsp_err;
`ifdef MEM_RESP_ADDR_ECHO_EN
   logic [ADDR_SIZE-1:0] rsp_addr;

   modport master (
      output req_valid, req_addr, req_we, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_addr
   );
   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_addr
   );
`else
   modport master (
      output req_valid, req_addr, req_we, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );
   modport slave (
      input  req_valid, req_addr, req_we, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
`endif
endinterface

// File: rtl/mem_addr_responder.sv
// Memory-end responder: accepts one request at a time, waits WAIT_STATES cycles, then responds.
// Defining MEM_RESP_ADDR_ECHO_EN adds the registered rsp_addr response field.
module mem_addr_responder #(
   parameter int ADDR_SIZE   = 19,
   parameter int DATA_SIZE   = 19,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_addr_responder_if.slave  bus
);
   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_STATES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [ADDR_SIZE-1:0] addr_q;
   logic                 we_q;
   logic [DATA_SIZE-1:0] wdata_q;
   logic                 req_ready_q;
   logic                 rsp_valid_q;
   logic [DATA_SIZE-1:0] rsp_rdata_q;
   logic                 rsp_err_q;
   logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];

   logic                 accept_s;
   logic                 access_s;
   logic [ADDR_SIZE-1:0] acc_addr_s;
   logic                 acc_we_s;
   logic [DATA_SIZE-1:0] acc_wdata_s;
   logic                 in_range_s;
   logic                 mem_we_s;

   // With no wait states the access happens on the accept edge, so it uses the live bus fields.
   always_comb begin
      accept_s    = (state_q == S_IDLE) && bus.req_valid && req_ready_q;
      access_s    = 1'b0;
      acc_addr_s  = addr_q;
      acc_we_s    = we_q;
      acc_wdata_s = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s && (WAIT_STATES == 0)) begin
               access_s    = 1'b1;
               acc_addr_s  = bus.req_addr;
               acc_we_s    = bus.req_we;
               acc_wdata_s = bus.req_wdata;
            end else begin
               access_s = 1'b0;
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               access_s = 1'b1;
            end else begin
               access_s = 1'b0;
            end
         end
         default: access_s = 1'b0;
      endcase
      in_range_s = ({1'b0, acc_addr_s} < (ADDR_SIZE + 1)'(MEM_DEPTH));
      mem_we_s   = access_s && acc_we_s && in_range_s && !rst;
   end

   // Storage is deliberately not reset; a reset on the access edge suppresses the write.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[acc_addr_s[IDX_W-1:0]] <= acc_wdata_s;
      end
   end

`ifdef MEM_RESP_ADDR_ECHO_EN
   logic [ADDR_SIZE-1:0] rsp_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_addr_q <= {ADDR_SIZE{1'b0}};
      end else if (access_s) begin
         rsp_addr_q <= acc_addr_s;
      end
   end

   assign bus.rsp_addr = rsp_addr_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         addr_q      <= {ADDR_SIZE{1'b0}};
         we_q        <= 1'b0;
         wdata_q     <= {DATA_SIZE{1'b0}};
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= {DATA_SIZE{1'b0}};
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept_s) begin
                  addr_q      <= bus.req_addr;
                  we_q        <= bus.req_we;
                  wdata_q     <= bus.req_wdata;
                  cnt_q       <= {CNT_W{1'b0}};
                  req_ready_q <= 1'b0;
                  state_q     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (access_s) begin
                  state_q <= S_RESP;
               end
            end
            S_RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  rsp_err_q   <= 1'b0;
                  req_ready_q <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b0;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
            end
         endcase
         if (access_s) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !in_range_s;
            rsp_rdata_q <= (in_range_s && !acc_we_s) ? mem_q[acc_addr_s[IDX_W-1:0]]
                                                     : {DATA_SIZE{1'b0}};
         end
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_mem_addr_responder.sv
// Bench for mem_addr_responder: one instance with two wait states, one with none, each checked
// against a word-array reference model. Echo checks follow MEM_RESP_ADDR_ECHO_EN.
module tb_mem_addr_responder;
   localparam int AW     = 19;
   localparam int DW     = 19;
   localparam int DEPTH  = 1024;
   localparam int WS_A   = 2;
   localparam int WS_B   = 0;
   localparam int BUDGET = 50;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_addr_responder_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus_a ();
   mem_addr_responder_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus_b ();

   mem_addr_responder #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS_A))
      dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   mem_addr_responder #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEM_DEPTH(DEPTH), .WAIT_STATES(WS_B))
      dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] mdl   [2][DEPTH];
   bit            known [2][DEPTH];
   int            pool  [8];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ne(input string tag, input logic [63:0] obs, input logic [63:0] bad);
      vectors++;
      assert (obs !== bad) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected anything but %0h", tag, obs, bad);
      end
   endtask

   task automatic drive(input int inst, input logic v, input logic [AW-1:0] ad, input logic we,
                        input logic [DW-1:0] wd, input logic rr);
      if (inst == 0) begin
         bus_a.req_valid = v; bus_a.req_addr = ad; bus_a.req_we = we;
         bus_a.req_wdata = wd; bus_a.rsp_ready = rr;
      end else begin
         bus_b.req_valid = v; bus_b.req_addr = ad; bus_b.req_we = we;
         bus_b.req_wdata = wd; bus_b.rsp_ready = rr;
      end
   endtask

   task automatic sample(input int inst, output logic v, output logic rdy, output logic [DW-1:0] d,
                         output logic e, output logic [AW-1:0] a);
      a = {AW{1'b0}};
      if (inst == 0) begin
         v = bus_a.rsp_valid; rdy = bus_a.req_ready; d = bus_a.rsp_rdata; e = bus_a.rsp_err;
`ifdef MEM_RESP_ADDR_ECHO_EN
         a = bus_a.rsp_addr;
`endif
      end else begin
         v = bus_b.rsp_valid; rdy = bus_b.req_ready; d = bus_b.rsp_rdata; e = bus_b.rsp_err;
`ifdef MEM_RESP_ADDR_ECHO_EN
         a = bus_b.rsp_addr;
`endif
      end
   endtask

   task automatic chk_reset(input int inst, input string tag);
      logic v, rdy, e;
      logic [DW-1:0] d;
      logic [AW-1:0] a;
      sample(inst, v, rdy, d, e, a);
      chk({tag, ".req_ready"}, 64'(rdy), 64'd0);
      chk({tag, ".rsp_valid"}, 64'(v), 64'd0);
      chk({tag, ".rsp_rdata"}, 64'(d), 64'd0);
      chk({tag, ".rsp_err"}, 64'(e), 64'd0);
`ifdef MEM_RESP_ADDR_ECHO_EN
      chk({tag, ".rsp_addr"}, 64'(a), 64'd0);
`endif
   endtask

   // One full transaction; hold>0 withholds rsp_ready while a competing request stays asserted.
   task automatic txn(input int inst, input logic [AW-1:0] ad, input logic we,
                      input logic [DW-1:0] wd, input int hold, input string tag,
                      output logic [DW-1:0] got);
      logic v, rdy, e, exp_e, chk_data;
      logic [DW-1:0] d, exp_d;
      logic [AW-1:0] a;
      int k, ws, idx;
      ws = (inst == 0) ? WS_A : WS_B;
      k = 0;
      sample(inst, v, rdy, d, e, a);
      while (!rdy && k < BUDGET) begin
         @(posedge clk); #1;
         sample(inst, v, rdy, d, e, a);
         k++;
      end
      chk({tag, ".ready_before"}, 64'(rdy), 64'd1);

      exp_e    = (int'(ad) >= DEPTH);
      idx      = exp_e ? 0 : int'(ad);
      chk_data = exp_e || we || known[inst][idx];
      exp_d    = (exp_e || we) ? {DW{1'b0}} : mdl[inst][idx];
      if (we && !exp_e) begin
         mdl[inst][idx]   = wd;
         known[inst][idx] = 1'b1;
      end

      drive(inst, 1'b1, ad, we, wd, (hold == 0));
      @(posedge clk); #1;
      if (hold == 0) drive(inst, 1'b0, ad, 1'b0, {DW{1'b0}}, 1'b1);
      else           drive(inst, 1'b1, ~ad, ~we, ~wd, 1'b0);
      sample(inst, v, rdy, d, e, a);
      chk({tag, ".ready_after_accept"}, 64'(rdy), 64'd0);

      k = 0;
      while (!v && k < BUDGET) begin
         @(posedge clk); #1;
         sample(inst, v, rdy, d, e, a);
         k++;
      end
      chk({tag, ".latency"}, 64'(k + 1), 64'(ws + 1));
      if (chk_data) chk({tag, ".rdata"}, 64'(d), 64'(exp_d));
      chk({tag, ".err"}, 64'(e), 64'(exp_e));
`ifdef MEM_RESP_ADDR_ECHO_EN
      chk({tag, ".echo"}, 64'(a), 64'(ad));
`endif
      got = d;

      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         sample(inst, v, rdy, d, e, a);
         chk({tag, ".hold_valid"}, 64'(v), 64'd1);
         chk({tag, ".hold_rdata"}, 64'(d), 64'(got));
         chk({tag, ".hold_err"}, 64'(e), 64'(exp_e));
         chk({tag, ".hold_ready"}, 64'(rdy), 64'd0);
      end
      drive(inst, 1'b0, ad, 1'b0, {DW{1'b0}}, 1'b1);
      @(posedge clk); #1;
      sample(inst, v, rdy, d, e, a);
      chk({tag, ".valid_done"}, 64'(v), 64'd0);
      chk({tag, ".err_done"}, 64'(e), 64'd0);
      chk({tag, ".ready_done"}, 64'(rdy), 64'd1);
   endtask

   initial begin
      logic [DW-1:0] got;
      logic [AW-1:0] ad;
      logic          we;
      int            inst;

      rst = 1'b1;
      drive(0, 1'b0, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0);
      drive(1, 1'b0, {AW{1'b0}}, 1'b0, {DW{1'b0}}, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk_reset(0, "reset_a");
      chk_reset(1, "reset_b");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_reset_a", 64'(bus_a.req_ready), 64'd1);
      chk("ready_after_reset_b", 64'(bus_b.req_ready), 64'd1);

      txn(0, 19'h00010, 1'b1, 19'h5A5A5, 0, "wr_10", got);
      txn(0, 19'h00010, 1'b0, 19'h00000, 0, "rd_10", got);
      txn(0, 19'h7FFFF, 1'b1, 19'h12345, 0, "wr_oor", got);
      txn(0, 19'h7FFFF, 1'b0, 19'h00000, 0, "rd_oor", got);
      txn(0, 19'h003FF, 1'b0, 19'h00000, 0, "rd_3ff", got);
      chk_ne("no_alias_3ff", 64'(got), 64'h12345);
      txn(0, 19'h00400, 1'b0, 19'h00000, 0, "rd_depth", got);
      txn(0, 19'h00010, 1'b0, 19'h00000, 5, "rd_bp", got);

      txn(1, 19'h00123, 1'b1, 19'h3C3C3, 0, "b_wr", got);
      txn(1, 19'h00123, 1'b0, 19'h00000, 0, "b_rd", got);
      txn(1, 19'h00123, 1'b0, 19'h00000, 2, "b_rd_bp", got);
      txn(1, 19'h40000, 1'b0, 19'h00000, 0, "b_oor", got);

      // Reset lands on the edge where the write would have been performed.
      drive(0, 1'b1, 19'h00020, 1'b1, 19'h11111, 1'b1);
      @(posedge clk); #1;
      drive(0, 1'b0, 19'h00020, 1'b0, 19'h00000, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset(0, "mid_reset_a");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_mid_reset", 64'(bus_a.req_ready), 64'd1);
      txn(0, 19'h00020, 1'b0, 19'h00000, 0, "rd_20", got);
      chk_ne("aborted_write_20", 64'(got), 64'h11111);

      for (int i = 0; i < 8; i++) pool[i] = int'($urandom_range(0, DEPTH - 1));
      for (int i = 0; i < 60; i++) begin
         inst = (i % 4 == 3) ? 1 : 0;
         if ($urandom_range(0, 9) == 0) ad = AW'($urandom_range(DEPTH, (2 ** AW) - 1));
         else                           ad = AW'(pool[$urandom_range(0, 7)]);
         we = 1'($urandom_range(0, 1));
         if (!we && int'(ad) < DEPTH && !known[inst][int'(ad)]) we = 1'b1;
         txn(inst, ad, we, DW'($urandom), int'($urandom_range(0, 3)), "rand", got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
